// File: rtl/controller_onchip_dram_arbiter_if.sv
// Bus bundle between two Avalon-MM pipelined requesters, the arbiter and the
// single-port on-chip data RAM.
//   m0_* / m1_* : requester command (address, byteenable, read, write,
//                 writedata) and response (waitrequest, readdata,
//                 readdatavalid)
//   ram_*       : RAM command outputs from the arbiter and ram_readdata back
// Handshake: a requester holds read/write with stable command fields until it
// samples waitrequest low at a rising edge; that edge accepts the command.
// A read returns exactly one cycle later, with readdatavalid high for one
// cycle. Reads are returned in acceptance order.
// Modports: slave = arbiter side, master = requester/RAM side.
interface controller_onchip_dram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic              ram_reset_req;
  logic [DATA_W-1:0] ram_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_chipselect, ram_write,
    output ram_writedata, ram_clken, ram_reset_req,
    input  ram_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write,
    input  ram_writedata, ram_clken, ram_reset_req,
    output ram_readdata
  );
endinterface

// File: rtl/controller_onchip_dram_arbiter.sv
// Two-requester round-robin arbiter in front of the 1024x32 single-port data
// RAM (byte-enabled, 1-cycle read latency, unregistered output).
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport carrying both Avalon-MM requester interfaces and
//             the RAM command/readdata signals
// One command can be granted every cycle. When both requesters ask, the one
// named by the priority pointer wins and the pointer then favours the other.
module controller_onchip_dram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  controller_onchip_dram_arbiter_if.slave bus
);

  logic              w_req0;
  logic              w_req1;
  logic              w_grant_valid;
  logic              w_winner;
  logic              w_win_read;
  logic              w_win_write;
  logic              w_rd_grant;
  logic [ADDR_W-1:0] w_address;
  logic [BE_W-1:0]   w_byteenable;
  logic [DATA_W-1:0] w_writedata;

  logic r_prio;      // 0: m0 preferred on contention
  logic r_rd_valid;  // a read was accepted at the last edge
  logic r_rd_id;     // which requester owns that read

  assign w_req0 = bus.m0_read | bus.m0_write;
  assign w_req1 = bus.m1_read | bus.m1_write;

  // Reset gates the grant combinationally so nothing reaches the RAM while
  // reset_n is low, whatever the requesters present.
  assign w_grant_valid = reset_n & (w_req0 | w_req1);
  assign w_winner      = (w_req0 & w_req1) ? r_prio : w_req1;

  always_comb begin
    w_address    = '0;
    w_byteenable = '0;
    w_writedata  = '0;
    w_win_read   = 1'b0;
    w_win_write  = 1'b0;
    if (w_grant_valid) begin
      if (w_winner) begin
        w_address    = bus.m1_address;
        w_byteenable = bus.m1_byteenable;
        w_writedata  = bus.m1_writedata;
        w_win_read   = bus.m1_read;
        w_win_write  = bus.m1_write;
      end else begin
        w_address    = bus.m0_address;
        w_byteenable = bus.m0_byteenable;
        w_writedata  = bus.m0_writedata;
        w_win_read   = bus.m0_read;
        w_win_write  = bus.m0_write;
      end
    end
  end

  // read+write together is executed as a write and produces no read return
  assign w_rd_grant = w_grant_valid & w_win_read & ~w_win_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      if (w_grant_valid) begin
        r_prio <= ~w_winner;
      end
      r_rd_valid <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_id <= w_winner;
      end
    end
  end

  // Stall while requesting and not granted; always stall during reset.
  assign bus.m0_waitrequest = ~reset_n | (w_req0 & ~(w_grant_valid & ~w_winner));
  assign bus.m1_waitrequest = ~reset_n | (w_req1 & ~(w_grant_valid &  w_winner));

  assign bus.m0_readdatavalid = r_rd_valid & ~r_rd_id;
  assign bus.m1_readdatavalid = r_rd_valid &  r_rd_id;
  assign bus.m0_readdata      = bus.ram_readdata;
  assign bus.m1_readdata      = bus.ram_readdata;

  assign bus.ram_address    = w_address;
  assign bus.ram_byteenable = w_byteenable;
  assign bus.ram_writedata  = w_writedata;
  assign bus.ram_chipselect = w_grant_valid;
  assign bus.ram_write      = w_win_write;
  assign bus.ram_clken      = 1'b1;
  assign bus.ram_reset_req  = 1'b0;

endmodule

// File: tb/tb_controller_onchip_dram_arbiter.sv
// Directed bench for controller_onchip_dram_arbiter with a behavioural
// 1024x32 byte-enabled RAM (registered read, 1-cycle latency).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_controller_onchip_dram_arbiter;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  controller_onchip_dram_arbiter_if bus ();

  controller_onchip_dram_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:1023];
  logic [31:0] ram_q;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_q = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.ram_chipselect && bus.ram_clken) begin
      if (bus.ram_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_byteenable[b]) mem[bus.ram_address][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
      end else begin
        ram_q <= mem[bus.ram_address];
      end
    end
  end

  assign bus.ram_readdata = ram_q;

  // ---------------- driver tasks ----------------
  task automatic drive_m0(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
    bus.m0_byteenable = be; bus.m0_writedata = d;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
    bus.m1_byteenable = be; bus.m1_writedata = d;
  endtask

  task automatic drive_idle();
    drive_m0(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
    drive_m1(1'b0, 1'b1, 10'h002, 4'hF, 32'h12345678);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait got=%b exp=1", bus.m0_waitrequest); end
    checks++; if (bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait got=%b exp=1", bus.m1_waitrequest); end
    checks++; if (bus.ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got=%b exp=0", bus.ram_chipselect); end
    checks++; if (bus.ram_write !== 1'b0) begin errors++; $display("FAIL rst_ram_write got=%b exp=0", bus.ram_write); end
    checks++; if (bus.ram_clken !== 1'b1) begin errors++; $display("FAIL rst_clken got=%b exp=1", bus.ram_clken); end
    checks++; if (bus.ram_reset_req !== 1'b0) begin errors++; $display("FAIL rst_reset_req got=%b exp=0", bus.ram_reset_req); end
    checks++; if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv got=%b%b exp=00", bus.m0_readdatavalid, bus.m1_readdatavalid); end
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL idle_wait got=%b%b exp=00", bus.m0_waitrequest, bus.m1_waitrequest); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive_m0(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait got=%b exp=0", bus.m0_waitrequest); end
    checks++; if (bus.ram_chipselect !== 1'b1 || bus.ram_write !== 1'b1) begin errors++; $display("FAIL wr_ram_cmd got=%b%b exp=11", bus.ram_chipselect, bus.ram_write); end
    checks++; if (bus.ram_address !== 10'h005 || bus.ram_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_ram_addr_data got=%h/%h exp=005/deadbeef", bus.ram_address, bus.ram_writedata); end
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait got=%b exp=0", bus.m0_waitrequest); end
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL wr_no_rdv got=%b exp=0", bus.m0_readdatavalid); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_rdv got=%b exp=1", bus.m0_readdatavalid); end
    checks++; if (bus.m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", bus.m0_readdata); end
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rdv got=%b exp=0", bus.m1_readdatavalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv_pulse got=%b exp=0", bus.m0_readdatavalid); end
  endtask

  task automatic test_byte_lanes();
    @(negedge clk);
    drive_m0(1'b0, 1'b1, 10'h3FF, 4'hF, 32'h11223344);
    @(negedge clk);
    drive_m0(1'b0, 1'b1, 10'h3FF, 4'h8, 32'hAA000000);
    #1;
    checks++; if (bus.ram_byteenable !== 4'h8) begin errors++; $display("FAIL be_lanes got=%h exp=8", bus.ram_byteenable); end
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hAA223344) begin errors++; $display("FAIL be_read got=%b/%h exp=1/aa223344", bus.m0_readdatavalid, bus.m0_readdata); end
  endtask

  task automatic test_illegal_rw();
    @(negedge clk);
    drive_m0(1'b1, 1'b1, 10'h010, 4'hF, 32'h5A5A5A5A);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.ram_write !== 1'b1) begin errors++; $display("FAIL ill_cmd got=%b%b exp=01", bus.m0_waitrequest, bus.ram_write); end
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL ill_no_rdv got=%b exp=0", bus.m0_readdatavalid); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL ill_read got=%b/%h exp=1/5a5a5a5a", bus.m0_readdatavalid, bus.m0_readdata); end
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL ill_m1_rdv got=%b exp=0", bus.m1_readdatavalid); end
  endtask

  // Both requesters read continuously straight out of reset. The preload is
  // done by m0 so the pointer favours m1 before reset; reset must clear it.
  task automatic test_contention();
    int          n0, n1, p0, p1;
    logic        prev_v, prev_id;
    logic [31:0] prev_d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) drive_m0(1'b0, 1'b1, 10'h100 + 10'(i), 4'hF, 32'hC0DE0000 + 32'(i));
      else       drive_m0(1'b0, 1'b1, 10'h200 + 10'(i - 4), 4'hF, 32'hB0B00000 + 32'(i - 4));
    end
    do_reset();
    n0 = 0; n1 = 0; p0 = 0; p1 = 0;
    prev_v = 1'b0; prev_id = 1'b0; prev_d = 32'h0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(negedge clk);
      if (j < 8) begin
        drive_m0(1'b1, 1'b0, 10'h100 + 10'(n0), 4'hF, 32'h0);
        drive_m1(1'b1, 1'b0, 10'h200 + 10'(n1), 4'hF, 32'h0);
      end else begin
        drive_idle();
      end
      #1;
      if (bus.m0_readdatavalid === 1'b1) p0++;
      if (bus.m1_readdatavalid === 1'b1) p1++;
      checks++; if (bus.m0_readdatavalid !== (prev_v && !prev_id) || bus.m1_readdatavalid !== (prev_v && prev_id)) begin errors++; $display("FAIL cont_rdv cyc=%0d got=%b%b exp=%b%b", j, bus.m0_readdatavalid, bus.m1_readdatavalid, prev_v && !prev_id, prev_v && prev_id); end
      if (prev_v) begin
        checks++; if (bus.m0_readdata !== prev_d) begin errors++; $display("FAIL cont_data cyc=%0d got=%h exp=%h", j, bus.m0_readdata, prev_d); end
      end
      prev_v = 1'b0;
      if (j < 8) begin
        checks++; if (bus.m0_waitrequest !== 1'((j % 2) == 1) || bus.m1_waitrequest !== 1'((j % 2) == 0)) begin errors++; $display("FAIL cont_wait cyc=%0d got=%b%b exp=%b%b", j, bus.m0_waitrequest, bus.m1_waitrequest, (j % 2) == 1, (j % 2) == 0); end
        prev_v = 1'b1;
        if ((j % 2) == 0) begin prev_id = 1'b0; prev_d = 32'hC0DE0000 + 32'(n0); n0++; end
        else              begin prev_id = 1'b1; prev_d = 32'hB0B00000 + 32'(n1); n1++; end
      end
    end
    checks++; if (p0 != 4 || p1 != 4) begin errors++; $display("FAIL cont_pulses got=%0d/%0d exp=4/4", p0, p1); end
  endtask

  task automatic test_single_requester();
    // m0 alone first so the pointer favours m1; m1 traffic must return it to m0
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 10'h100, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_m0_wait got=%b exp=0", bus.m0_waitrequest); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_m0(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      if (i < 5) drive_m1(1'b1, 1'b0, 10'h200 + 10'(i % 4), 4'hF, 32'h0);
      else       drive_m1(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      #1;
      if (i == 0) begin
        checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hC0DE0000) begin errors++; $display("FAIL single_m0_rd got=%b/%h exp=1/c0de0000", bus.m0_readdatavalid, bus.m0_readdata); end
      end else begin
        checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'hB0B00000 + 32'((i - 1) % 4)) begin errors++; $display("FAIL single_m1_rd i=%0d got=%b/%h exp=1/%h", i, bus.m1_readdatavalid, bus.m1_readdata, 32'hB0B00000 + 32'((i - 1) % 4)); end
      end
      if (i < 5) begin
        checks++; if (bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL single_m1_wait i=%0d got=%b exp=0", i, bus.m1_waitrequest); end
      end
    end
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 10'h101, 4'hF, 32'h0);
    drive_m1(1'b1, 1'b0, 10'h201, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL single_prio got=%b%b exp=01", bus.m0_waitrequest, bus.m1_waitrequest); end
    @(negedge clk);
    drive_m0(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    #1;
    checks++; if (bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL single_m1_next got=%b exp=0", bus.m1_waitrequest); end
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hC0DE0001) begin errors++; $display("FAIL single_m0_rd2 got=%b/%h exp=1/c0de0001", bus.m0_readdatavalid, bus.m0_readdata); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'hB0B00001) begin errors++; $display("FAIL single_m1_rd2 got=%b/%h exp=1/b0b00001", bus.m1_readdatavalid, bus.m1_readdata); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    drive_m1(1'b1, 1'b0, 10'h202, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_grant got=%b exp=0", bus.m1_waitrequest); end
    @(negedge clk);
    reset_n = 1'b0;
    drive_m0(1'b1, 1'b0, 10'h102, 4'hF, 32'h0);
    drive_m1(1'b1, 1'b0, 10'h202, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_rdv got=%b exp=0", bus.m1_readdatavalid); end
    checks++; if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_wait got=%b%b exp=11", bus.m0_waitrequest, bus.m1_waitrequest); end
    checks++; if (bus.ram_chipselect !== 1'b0) begin errors++; $display("FAIL mid_cs got=%b exp=0", bus.ram_chipselect); end
    @(negedge clk);
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b0 || bus.ram_chipselect !== 1'b0) begin errors++; $display("FAIL mid_hold got=%b%b exp=00", bus.m1_readdatavalid, bus.ram_chipselect); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_release_prio got=%b%b exp=01", bus.m0_waitrequest, bus.m1_waitrequest); end
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_release_rdv got=%b exp=0", bus.m1_readdatavalid); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hC0DE0002) begin errors++; $display("FAIL mid_after got=%b/%h exp=1/c0de0002", bus.m0_readdatavalid, bus.m0_readdata); end
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_after_m1 got=%b exp=0", bus.m1_readdatavalid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    drive_idle();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_illegal_rw();
    test_contention();
    test_single_requester();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
